// File: rtl/lmem_pipe_if.sv
// Request/response bundle for the dual-port pipelined local memory.
// The master drives requests and the slave (lmem_pipe) returns read data and collision status.
interface lmem_pipe_if #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  en_a;
    logic                  en_b;
    logic                  we_a;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  qvalid_a;
    logic                  qvalid_b;
    logic                  collision;
    logic [15:0]           collision_cnt;

    modport master (
        output en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b,
        input  q_a, q_b, qvalid_a, qvalid_b, collision, collision_cnt
    );

    modport slave (
        input  en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b,
        output q_a, q_b, qvalid_a, qvalid_b, collision, collision_cnt
    );
endinterface

// File: rtl/lmem_pipe.sv
// True-dual-port memory with a fixed-latency read pipeline per port, configurable
// read-during-write behaviour, dual-write priority and a saturating collision counter.
module lmem_pipe #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RD_LATENCY = 2,
    parameter bit          RDW_MODE   = 1'b0,
    parameter bit          WR_PRIO_B  = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    lmem_pipe_if.slave   bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    logic                  wr_a;
    logic                  wr_b;
    logic                  coll;
    logic [DATA_WIDTH-1:0] pipe_a [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_b [RD_LATENCY];
    logic [RD_LATENCY-1:0] vld_a;
    logic [RD_LATENCY-1:0] vld_b;
    logic                  collision_q;
    logic [15:0]           cnt_q;

    always_comb begin
        wr_a = bus.en_a & bus.we_a;
        wr_b = bus.en_b & bus.we_b;
        coll = wr_a & wr_b & (bus.addr_a == bus.addr_b);
    end

    // Array kept free of reset so it maps onto block RAM; the losing port is masked on a collision.
    always_ff @(posedge clk) begin
        if (wr_a && !(coll && WR_PRIO_B)) begin
            mem[bus.addr_a] <= bus.data_a;
        end
        if (wr_b && !(coll && !WR_PRIO_B)) begin
            mem[bus.addr_b] <= bus.data_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_a <= '0;
            vld_b <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            vld_a[0] <= bus.en_a;
            vld_b[0] <= bus.en_b;
            // Stage 0 samples the pre-edge array, so cross-port reads see the old word.
            if (bus.en_a) begin
                pipe_a[0] <= (bus.we_a && !RDW_MODE) ? bus.data_a : mem[bus.addr_a];
            end
            if (bus.en_b) begin
                pipe_b[0] <= (bus.we_b && !RDW_MODE) ? bus.data_b : mem[bus.addr_b];
            end
            // Later stages only advance behind a valid word, so q holds between pulses.
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_a[i] <= vld_a[i-1];
                vld_b[i] <= vld_b[i-1];
                if (vld_a[i-1]) begin
                    pipe_a[i] <= pipe_a[i-1];
                end
                if (vld_b[i-1]) begin
                    pipe_b[i] <= pipe_b[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            collision_q <= coll;
            if (coll && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.q_a           = pipe_a[RD_LATENCY-1];
    assign bus.q_b           = pipe_b[RD_LATENCY-1];
    assign bus.qvalid_a      = vld_a[RD_LATENCY-1];
    assign bus.qvalid_b      = vld_b[RD_LATENCY-1];
    assign bus.collision     = collision_q;
    assign bus.collision_cnt = cnt_q;
endmodule

// File: doc/lmem_pipe.md
LMEM_PIPE -- requirements
Module: lmem_pipe

Interface
REQ-001: Parameter DATA_WIDTH, default 18, sets the word width in bits.
REQ-002: Parameter ADDR_WIDTH, default 10, sets the depth to 2**ADDR_WIDTH words.
REQ-003: Parameter RD_LATENCY, default 2, legal range 1..4, sets the cycles from request to output valid.
REQ-004: Parameter RDW_MODE, default 0: on a same-port write, 0 = q returns the new data (write-first), 1 = q returns the old data (read-first).
REQ-005: Parameter WR_PRIO_B, default 0: on a same-address dual write, 0 = port A data is stored, 1 = port B data is stored.
REQ-006: clk  input  1  single clock; all state updates on its rising edge.
REQ-007: rst_n  input  1  asynchronous, active-low reset.
REQ-008: en_a, en_b  input  1 each  request strobe per port.
REQ-009: we_a, we_b  input  1 each  write select, qualified by en.
REQ-010: addr_a, addr_b  input  ADDR_WIDTH each  word address.
REQ-011: data_a, data_b  input  DATA_WIDTH each  write data.
REQ-012: q_a, q_b  output  DATA_WIDTH each  registered read data.
REQ-013: qvalid_a, qvalid_b  output  1 each  high for one cycle when q carries the result of a request.
REQ-014: collision  output  1  one-cycle pulse flagging a same-address dual write.
REQ-015: collision_cnt  output  16  saturating count of collisions.

Function
REQ-016: A port request is accepted in every cycle with en high; there is no backpressure and no stall.
REQ-017: Accepted request with we high writes data to addr at that edge; with we low it reads addr.
REQ-018: Every accepted request, read or write, produces exactly one qvalid pulse exactly RD_LATENCY cycles after acceptance, in request order, back-to-back capable (one per cycle).
REQ-019: Write request q value follows RDW_MODE; read request q is the word stored at the acceptance edge.
REQ-020: Cross-port read of an address written by the other port in the same cycle returns the old word.
REQ-021: Same-address dual write (en_a&we_a&en_b&we_b, addr_a==addr_b) stores per WR_PRIO_B; each port's q for that write still follows RDW_MODE using its own data.
REQ-022: Collision pulse is registered: asserted on the edge after the colliding request cycle, for one cycle per collision.
REQ-023: collision_cnt increments on each collision pulse and holds at 16'hFFFF.
REQ-024: q_a/q_b hold their last value when qvalid is low.
REQ-025: Read-latency pipeline stages beyond the first are plain registers (no RAM in them) so the array infers as true-dual-port block RAM.

Reset
REQ-026: rst_n low immediately clears qvalid_a, qvalid_b, collision, q_a, q_b and collision_cnt to 0, and clears all in-flight pipeline valid bits.
REQ-027: Requests in flight at reset assertion produce no qvalid after release; RAM contents are not cleared.
REQ-028: Requests with en high during reset are ignored; the first request accepted is on the first rising edge with rst_n high.

Verification
REQ-029: RD_LATENCY=2: write 0x155 to A[5] at cycle 0, read A[5] at cycle 1 -> qvalid_a at cycles 2 and 3, q_a=0x155 at cycle 3.
REQ-030: RDW_MODE=1: A[7]=0x011, write 0x022 to A[7] -> q_a=0x011 with qvalid; then read -> 0x022.
REQ-031: Same cycle: A writes 0x3AA to addr 9, B reads addr 9 (old 0x001) -> q_b=0x001; next read by B -> 0x3AA.
REQ-032: WR_PRIO_B=0: both ports write addr 4 (A=0x0AA, B=0x0BB) -> collision pulse one cycle later, collision_cnt=1, subsequent read of addr 4 = 0x0AA.
REQ-033: Read streams on both ports for 10 consecutive cycles -> 10 qvalid pulses each, contiguous, addresses in order.
REQ-034: Assert rst_n low with 2 reads in flight -> all outputs 0 at once, no qvalid after release, previously written data still readable.
